// File: rtl/pid_cfg_loader.sv
// rtl/pid_cfg_loader.sv - framed byte-stream decoder that writes PID gain registers
module pid_cfg_loader #(
    parameter int         D_WIDTH   = 18,
    parameter int         NUM_REGS  = 4,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         TIMEOUT   = 1000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    input  logic               iterate_enable,
    output logic               write_enable,
    output logic [D_WIDTH-1:0] reg_addr,
    output logic [D_WIDTH-1:0] reg_data,
    output logic               frame_ok,
    output logic               frame_err,
    output logic [1:0]         err_code
);

    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam int TOPW = 25 - D_WIDTH;
    localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);

    typedef enum logic [2:0] {
        S_HUNT, S_ADDR, S_D2, S_D1, S_D0, S_CSUM, S_WAIT_WR, S_STROBE
    } state_t;

    state_t          state;
    logic [TW-1:0]   gap;
    logic [7:0]      addr_q;
    logic [23:0]     raw_q;
    logic            timeout_q;
    logic            in_frame;
    logic            take;
    logic            strobe;
    logic            expire;
    logic            csum_bad;
    logic            addr_bad;
    logic            range_ok;
    logic [TOPW-1:0] raw_top;

    assign in_frame = (state == S_ADDR) || (state == S_D2) || (state == S_D1) ||
                      (state == S_D0) || (state == S_CSUM);

    // The cycle right after a timeout refuses bytes so a late byte cannot start a new frame.
    assign rx_ready = !reset && !timeout_q && ((state == S_HUNT) || in_frame);
    assign take     = rx_valid && rx_ready;
    assign expire   = in_frame && !take && (gap == TW'(TIMEOUT - 2));

    // Strobe is gated by the live iterate_enable so a write never overlaps an iteration.
    assign strobe       = !reset && (state == S_STROBE) && !iterate_enable;
    assign write_enable = !strobe;
    assign frame_ok     = strobe;

    assign csum_bad = (addr_q ^ raw_q[23:16] ^ raw_q[15:8] ^ raw_q[7:0]) != rx_data;
    assign addr_bad = {1'b0, addr_q} >= NUM_REGS_W;
    assign raw_top  = raw_q[23:D_WIDTH-1];
    assign range_ok = (raw_top == '0) || (raw_top == '1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_HUNT;
            gap       <= '0;
            addr_q    <= '0;
            raw_q     <= '0;
            reg_addr  <= '0;
            reg_data  <= '0;
            frame_err <= 1'b0;
            err_code  <= 2'd0;
            timeout_q <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            timeout_q <= 1'b0;
            if (take || !in_frame) begin
                gap <= '0;
            end else begin
                gap <= gap + TW'(1);
            end

            case (state)
                S_HUNT: begin
                    if (take && (rx_data == SYNC_BYTE)) begin
                        state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (take) begin
                        addr_q <= rx_data;
                        state  <= S_D2;
                    end
                end
                S_D2: begin
                    if (take) begin
                        raw_q[23:16] <= rx_data;
                        state        <= S_D1;
                    end
                end
                S_D1: begin
                    if (take) begin
                        raw_q[15:8] <= rx_data;
                        state       <= S_D0;
                    end
                end
                S_D0: begin
                    if (take) begin
                        raw_q[7:0] <= rx_data;
                        state      <= S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (take) begin
                        if (csum_bad) begin
                            frame_err <= 1'b1;
                            err_code  <= 2'd1;
                            state     <= S_HUNT;
                        end else if (addr_bad) begin
                            frame_err <= 1'b1;
                            err_code  <= 2'd2;
                            state     <= S_HUNT;
                        end else if (!range_ok) begin
                            frame_err <= 1'b1;
                            err_code  <= 2'd3;
                            state     <= S_HUNT;
                        end else begin
                            reg_addr <= {{(D_WIDTH-8){1'b0}}, addr_q};
                            reg_data <= raw_q[D_WIDTH-1:0];
                            state    <= S_WAIT_WR;
                        end
                    end
                end
                S_WAIT_WR: begin
                    if (!iterate_enable) begin
                        state <= S_STROBE;
                    end
                end
                S_STROBE: begin
                    if (!iterate_enable) begin
                        state <= S_HUNT;
                    end
                end
                default: state <= S_HUNT;
            endcase

            if (expire) begin
                state     <= S_HUNT;
                frame_err <= 1'b1;
                err_code  <= 2'd0;
                timeout_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pid_cfg_loader.sv
// tb/tb_pid_cfg_loader.sv - directed self-checking bench for pid_cfg_loader
module tb_pid_cfg_loader;

    localparam int DW = 18;
    localparam int TO = 1000;

    logic          clock = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          iterate_enable;
    logic          write_enable;
    logic [DW-1:0] reg_addr;
    logic [DW-1:0] reg_data;
    logic          frame_ok;
    logic          frame_err;
    logic [1:0]    err_code;

    int checks   = 0;
    int failures = 0;

    pid_cfg_loader #(.D_WIDTH(DW), .NUM_REGS(4), .SYNC_BYTE(8'hA5), .TIMEOUT(TO)) dut (
        .clock(clock),
        .reset(reset),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .iterate_enable(iterate_enable),
        .write_enable(write_enable),
        .reg_addr(reg_addr),
        .reg_data(reg_data),
        .frame_ok(frame_ok),
        .frame_err(frame_err),
        .err_code(err_code)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one byte and returns just after the handshake edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clock);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("rx_ready_for_byte", 32'(rx_ready), 32'd1);
        @(posedge clock);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d2,
                              input logic [7:0] d1, input logic [7:0] d0,
                              input logic [7:0] cs);
        send_byte(8'hA5);
        send_byte(a);
        send_byte(d2);
        send_byte(d1);
        send_byte(d0);
        send_byte(cs);
    endtask

    task automatic expect_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clock);
        check({tag, "_t1_we"}, 32'(write_enable), 32'd1);
        check({tag, "_t1_ready"}, 32'(rx_ready), 32'd0);
        @(negedge clock);
        check({tag, "_t2_we"}, 32'(write_enable), 32'd0);
        check({tag, "_t2_ok"}, 32'(frame_ok), 32'd1);
        check({tag, "_t2_ready"}, 32'(rx_ready), 32'd0);
        check({tag, "_addr"}, 32'(reg_addr), addr);
        check({tag, "_data"}, 32'(reg_data), data);
        @(negedge clock);
        check({tag, "_t3_we"}, 32'(write_enable), 32'd1);
        check({tag, "_t3_ready"}, 32'(rx_ready), 32'd1);
    endtask

    task automatic expect_err(input string tag, input logic [31:0] code);
        @(negedge clock);
        check({tag, "_err"}, 32'(frame_err), 32'd1);
        check({tag, "_code"}, 32'(err_code), code);
        check({tag, "_t1_we"}, 32'(write_enable), 32'd1);
        @(negedge clock);
        check({tag, "_err_off"}, 32'(frame_err), 32'd0);
        check({tag, "_t2_we"}, 32'(write_enable), 32'd1);
        check({tag, "_t2_ready"}, 32'(rx_ready), 32'd1);
    endtask

    initial begin
        int bad;
        reset          = 1'b1;
        rx_data        = 8'h00;
        rx_valid       = 1'b0;
        iterate_enable = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("rst_ready", 32'(rx_ready), 32'd0);
        check("rst_we", 32'(write_enable), 32'd1);
        check("rst_addr", 32'(reg_addr), 32'd0);
        check("rst_data", 32'(reg_data), 32'd0);
        check("rst_ok", 32'(frame_ok), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_code", 32'(err_code), 32'd0);
        reset = 1'b0;

        send_frame(8'h01, 8'h00, 8'h40, 8'h00, 8'h41);
        expect_write("good", 32'd1, 32'h04000);

        send_frame(8'h02, 8'hFE, 8'h00, 8'h00, 8'hFC);
        expect_write("neg", 32'd2, 32'h20000);

        send_frame(8'h01, 8'h02, 8'h00, 8'h00, 8'h03);
        expect_err("range", 32'd3);
        check("range_data_kept", 32'(reg_data), 32'h20000);

        send_frame(8'h04, 8'h00, 8'h00, 8'h01, 8'h05);
        expect_err("addr", 32'd2);

        send_frame(8'h01, 8'h00, 8'h40, 8'h00, 8'h40);
        expect_err("csum", 32'd1);
        @(negedge clock);
        check("code_held", 32'(err_code), 32'd1);

        // Timeout: frame_err lands TO cycles after the ADDR handshake.
        send_byte(8'hA5);
        send_byte(8'h01);
        bad = 0;
        for (int k = 1; k <= TO + 1; k++) begin
            @(negedge clock);
            if (k < TO && frame_err) bad++;
            if (k == TO - 1) check("to_ready_before", 32'(rx_ready), 32'd1);
            if (k == TO) begin
                check("to_err", 32'(frame_err), 32'd1);
                check("to_code", 32'(err_code), 32'd0);
                check("to_ready", 32'(rx_ready), 32'd0);
            end
            if (k == TO + 1) begin
                check("to_err_off", 32'(frame_err), 32'd0);
                check("to_ready_after", 32'(rx_ready), 32'd1);
            end
        end
        check("to_no_early_err", 32'(bad), 32'd0);
        send_frame(8'h01, 8'h00, 8'h40, 8'h00, 8'h41);
        expect_write("after_to", 32'd1, 32'h04000);

        // Stall: iterate_enable high for the CSUM cycle and the next six.
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h05);
        iterate_enable = 1'b1;
        send_byte(8'h06);
        bad = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            if (!write_enable || frame_ok || rx_ready) bad++;
        end
        check("stall_held", 32'(bad), 32'd0);
        @(negedge clock);
        iterate_enable = 1'b0;
        #1 check("stall_t7_we", 32'(write_enable), 32'd1);
        @(negedge clock);
        check("stall_we", 32'(write_enable), 32'd0);
        check("stall_ok", 32'(frame_ok), 32'd1);
        check("stall_addr", 32'(reg_addr), 32'd3);
        check("stall_data", 32'(reg_data), 32'd5);
        @(negedge clock);
        check("stall_we_off", 32'(write_enable), 32'd1);
        check("stall_ready", 32'(rx_ready), 32'd1);

        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h13);
        send_frame(8'h00, 8'h00, 8'h00, 8'h07, 8'h07);
        expect_write("noise", 32'd0, 32'd7);

        // Reset after D1 abandons the frame silently.
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h40);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("mrst_ready", 32'(rx_ready), 32'd0);
        check("mrst_we", 32'(write_enable), 32'd1);
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (frame_err || !write_enable) bad++;
        end
        check("mrst_quiet", 32'(bad), 32'd0);
        check("mrst_addr", 32'(reg_addr), 32'd0);
        send_frame(8'h03, 8'h01, 8'h23, 8'h45, 8'h64);
        expect_write("post_rst", 32'd3, 32'h12345);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
